ifetch_buffer: RTL

Instruction prefetch queue between the instruction memory and the fetch stage of the pipelined CPU. Drives the imem address, captures each fetched word with its PC into a small FIFO, and delivers {PC, instruction} pairs over a valid/ready handshake. This decouples sequential fetch from pipeline stalls. A flush input, driven by the branch/jump resolution logic, discards queued entries and restarts fetch at a new address.

---
 rtl/ifetch_buffer.sv | 97 +++++++++
 1 files changed

// File: rtl/ifetch_buffer.sv
// Instruction prefetch queue: fetches sequentially from imem into a DEPTH-entry FIFO of {pc, instr}.
// Optional macro IFB_BYPASS_EN passes the fetched word straight to the consumer when the queue is empty.
module ifetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              imem_addr,
    input  logic [31:0]              imem_rdata,
    input  logic                     flush,
    input  logic [31:0]              flush_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [31:0]     fetch_pc;
    logic            queue_valid;
    logic            bypass;
    logic            bypass_take;
    logic            pop_q;
    logic            push;
    logic            advance;

    assign imem_addr   = fetch_pc;
    assign queue_valid = (count != '0);

`ifdef IFB_BYPASS_EN
    assign bypass = !queue_valid && !flush;
`else
    assign bypass = 1'b0;
`endif

    // Handshake decode; a word consumed through the bypass never touches storage.
    always_comb begin
        pop_q       = queue_valid && out_ready;
        bypass_take = bypass && out_ready;
        push        = !flush && !bypass_take && ((count < CW'(DEPTH)) || pop_q);
        advance     = push || bypass_take;
    end

    // Head presentation: stored entry, bypassed fetch word, or idle NOP.
    always_comb begin
        out_valid = queue_valid || bypass;
        out_pc    = 32'h0;
        out_instr = NOP;
        if (queue_valid) begin
            out_pc    = mem[rd_ptr].pc;
            out_instr = mem[rd_ptr].instr;
        end else if (bypass) begin
            out_pc    = fetch_pc;
            out_instr = imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc: fetch_pc, instr: imem_rdata};
        end
    end

    // Pointers, occupancy and fetch address; flush overrides every other update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
        end else if (flush) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            fetch_pc <= flush_pc & ~32'h3;
        end else begin
            if (push)    wr_ptr   <= wr_ptr + PW'(1);
            if (pop_q)   rd_ptr   <= rd_ptr + PW'(1);
            if (advance) fetch_pc <= fetch_pc + 32'd4;
            count <= count + CW'(push) - CW'(pop_q);
        end
    end

endmodule
